// File: rtl/hex_operand_editor.sv
// Purpose : button-driven editor building two 32-bit operands (Ai/Bi) one nibble at a time,
//           with press edge detection, cursor movement and hold-to-repeat on U/D.
// Latency : a press sampled on a rising edge is reflected in the registered outputs after that edge;
//           no backpressure, one action per cycle (C > U > D > L > R).
// Ports   : clk, RSTN (sync active-low), btn_ok[4:0] = {L,U,R,D,C}, sel (0=Ai,1=Bi),
//           Ai/Bi operands, cursor (selected nibble), blink (one-hot of cursor).
// Option  : define HEX_OPERAND_EDITOR_BCD_EN to make U/D wrap within 0..9.
module hex_operand_editor #(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 27
) (
    input  logic        clk,
    input  logic        RSTN,
    input  logic [4:0]  btn_ok,
    input  logic        sel,
    output logic [31:0] Ai,
    output logic [31:0] Bi,
    output logic [2:0]  cursor,
    output logic [7:0]  blink
);

    typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic [31:0]      ai_q, ai_d, bi_q, bi_d;
    logic [2:0]       cursor_q, cursor_d;
    logic [7:0]       blink_q;
    logic [4:0]       btn_prev_q;
    state_t           state_q, state_d;
    logic             rep_dn_q, rep_dn_d;   // 0 = repeat U, 1 = repeat D
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [4:0]  press;
    logic        act_c, act_u, act_d, act_l, act_r;
    logic        rep_held, fire, step_dn;
    logic [31:0] op_cur, op_upd;
    logic [4:0]  nib_lsb;

    function automatic logic [3:0] nib_step(input logic [3:0] n, input logic dn);
`ifdef HEX_OPERAND_EDITOR_BCD_EN
        // Out-of-range digits (A..F) snap to the wrap target of the step direction.
        if (dn) nib_step = (n == 4'd0 || n > 4'd9) ? 4'd9 : n - 4'd1;
        else    nib_step = (n >= 4'd9) ? 4'd0 : n + 4'd1;
`else
        nib_step = dn ? n - 4'd1 : n + 4'd1;
`endif
    endfunction

    always_comb begin
        press = btn_ok & ~btn_prev_q;
        // Fixed priority: only the winning press acts, the rest are dropped.
        act_c = press[0];
        act_u = ~press[0] & press[3];
        act_d = ~press[0] & ~press[3] & press[1];
        act_l = ~press[0] & ~press[3] & ~press[1] & press[4];
        act_r = ~press[0] & ~press[3] & ~press[1] & ~press[4] & press[2];

        rep_held = rep_dn_q ? btn_ok[1] : btn_ok[3];
        fire     = ((state_q == HOLD) && (cnt_q == HOLD_LAST)) ||
                   ((state_q == RPT)  && (cnt_q == RPT_LAST));

        step_dn = (act_u | act_d) ? act_d : rep_dn_q;
        op_cur  = sel ? bi_q : ai_q;
        nib_lsb = {cursor_q, 2'b00};
        op_upd  = op_cur;
        op_upd[nib_lsb +: 4] = nib_step(op_cur[nib_lsb +: 4], step_dn);

        ai_d     = ai_q;
        bi_d     = bi_q;
        cursor_d = cursor_q;
        state_d  = state_q;
        rep_dn_d = rep_dn_q;
        cnt_d    = cnt_q;

        if (act_c) begin
            if (sel) bi_d = '0;
            else     ai_d = '0;
            cursor_d = '0;
            state_d  = IDLE;
            cnt_d    = '0;
        end else if (act_u | act_d) begin
            if (sel) bi_d = op_upd;
            else     ai_d = op_upd;
            rep_dn_d = act_d;
            cnt_d    = '0;
            state_d  = HOLD;
        end else if (act_l | act_r) begin
            cursor_d = act_l ? cursor_q + 3'd1 : cursor_q - 3'd1;
            state_d  = IDLE;
            cnt_d    = '0;
        end else if (state_q != IDLE) begin
            // Release beats a due repeat: nothing is applied on the release cycle.
            if (!rep_held) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else if (fire) begin
                if (sel) bi_d = op_upd;
                else     ai_d = op_upd;
                cnt_d   = '0;
                state_d = RPT;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!RSTN) begin
            ai_q       <= '0;
            bi_q       <= '0;
            cursor_q   <= '0;
            blink_q    <= 8'h01;
            btn_prev_q <= 5'b11111;   // buttons held through reset never look like a press
            state_q    <= IDLE;
            rep_dn_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            ai_q       <= ai_d;
            bi_q       <= bi_d;
            cursor_q   <= cursor_d;
            blink_q    <= 8'd1 << cursor_d;
            btn_prev_q <= btn_ok;
            state_q    <= state_d;
            rep_dn_q   <= rep_dn_d;
            cnt_q      <= cnt_d;
        end
    end

    assign Ai     = ai_q;
    assign Bi     = bi_q;
    assign cursor = cursor_q;
    assign blink  = blink_q;

endmodule

// File: tb/tb_hex_operand_editor.sv
// Purpose : randomized + directed check of hex_operand_editor against a behavioural model.
// Latency : model predicts the outputs after each rising edge; a monitor compares one cycle's worth per edge.
// Stimulus: inputs driven on falling edges, expected values queued at drive time.
module tb_hex_operand_editor;

    localparam int HOLD = 4;
    localparam int RPT  = 2;

    localparam logic [4:0] B_C = 5'b00001;
    localparam logic [4:0] B_D = 5'b00010;
    localparam logic [4:0] B_R = 5'b00100;
    localparam logic [4:0] B_U = 5'b01000;
    localparam logic [4:0] B_L = 5'b10000;

    logic        clk = 1'b1;
    logic        RSTN;
    logic [4:0]  btn_ok;
    logic        sel;
    logic [31:0] Ai, Bi;
    logic [2:0]  cursor;
    logic [7:0]  blink;

    hex_operand_editor #(.HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT), .CNT_W(4)) dut (
        .clk(clk), .RSTN(RSTN), .btn_ok(btn_ok), .sel(sel),
        .Ai(Ai), .Bi(Bi), .cursor(cursor), .blink(blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  c;
        logic [7:0]  bl;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: operands as plain integers, held button tracked as
    // "direction + edges left until next auto-step".
    logic [31:0] m_a, m_b;
    int          m_cur;
    logic [4:0]  m_prev;
    int          m_dir;    // 0 none, +1 up, -1 down
    int          m_wait;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int digit_step(input int n, input int dir);
`ifdef HEX_OPERAND_EDITOR_BCD_EN
        if (dir > 0) return (n >= 9) ? 0 : n + 1;
        return (n == 0 || n > 9) ? 9 : n - 1;
`else
        return (n + dir + 16) % 16;
`endif
    endfunction

    task automatic model_step_op(input int dir, input logic s);
        logic [31:0] op;
        int          n;
        op = s ? m_b : m_a;
        n  = int'((op >> (4 * m_cur)) & 32'hF);
        n  = digit_step(n, dir);
        op = (op & ~(32'hF << (4 * m_cur))) | (32'(n) << (4 * m_cur));
        if (s) m_b = op;
        else   m_a = op;
    endtask

    task automatic model_edge(input logic r, input logic [4:0] b, input logic s);
        logic [4:0] p;
        if (!r) begin
            m_a = 0; m_b = 0; m_cur = 0; m_prev = 5'h1F; m_dir = 0; m_wait = 0;
            return;
        end
        p = b & ~m_prev;
        m_prev = b;
        if (p[0]) begin
            if (s) m_b = 0; else m_a = 0;
            m_cur = 0; m_dir = 0;
        end else if (p[3] || p[1]) begin
            m_dir = p[3] ? 1 : -1;
            model_step_op(m_dir, s);
            m_wait = HOLD;
        end else if (p[4]) begin
            m_cur = (m_cur + 1) % 8; m_dir = 0;
        end else if (p[2]) begin
            m_cur = (m_cur + 7) % 8; m_dir = 0;
        end else if (m_dir != 0) begin
            if (!(m_dir > 0 ? b[3] : b[1])) m_dir = 0;
            else begin
                m_wait--;
                if (m_wait == 0) begin
                    model_step_op(m_dir, s);
                    m_wait = RPT;
                end
            end
        end
    endtask

    // One clock: drive on the falling edge, predict the following rising edge.
    task automatic cyc(input logic r, input logic [4:0] b, input logic s);
        exp_t e;
        @(negedge clk);
        RSTN = r; btn_ok = b; sel = s;
        model_edge(r, b, s);
        e.a = m_a; e.b = m_b; e.c = 3'(m_cur); e.bl = 8'd1 << m_cur;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [4:0] b, input logic s);
        cyc(1'b1, b, s);
        cyc(1'b1, 5'b0, s);
    endtask

    task automatic settle;
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge the DUT presents a new output set; pop and compare.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("Ai", Ai, e.a);
            check("Bi", Bi, e.b);
            check("cursor", 32'(cursor), 32'(e.c));
            check("blink", 32'(blink), 32'(e.bl));
        end
    end

    initial begin
        RSTN = 1'b0; btn_ok = B_U; sel = 1'b0;
        // Reset with U held, then release: no increment.
        repeat (3) cyc(1'b0, B_U, 1'b0);
        repeat (3) cyc(1'b1, B_U, 1'b0);
        cyc(1'b1, 5'b0, 1'b0);
        settle();
        check("rst_hold_Ai", Ai, 32'h0);
        check("rst_blink", 32'(blink), 32'h01);

        // U x3, L, D on Ai.
        repeat (3) pulse(B_U, 1'b0);
        pulse(B_L, 1'b0);
        pulse(B_D, 1'b0);
        settle();
        check("dir_Ai_F3", Ai, 32'h0000_00F3);
        check("dir_cursor1", 32'(cursor), 32'd1);
        check("dir_blink02", 32'(blink), 32'h02);

        // Bi: back to cursor 0, R wraps to 7, U on top nibble.
        pulse(B_R, 1'b1);
        pulse(B_R, 1'b1);
        settle();
        check("wrap_blink80", 32'(blink), 32'h80);
        pulse(B_U, 1'b1);
        settle();
        check("dir_Bi", Bi, 32'h1000_0000);
        check("dir_Ai_kept", Ai, 32'h0000_00F3);

        // Clear Ai, then hold U for 11 edges: steps at press, +4, +6, +8, +10.
        pulse(B_L, 1'b0);
        pulse(B_C, 1'b0);
        repeat (11) cyc(1'b1, B_U, 1'b0);
        repeat (6) cyc(1'b1, 5'b0, 1'b0);
        settle();
        check("hold_Ai_5", Ai, 32'h5);

        // Build 1234_5678, then U+C together.
        pulse(B_C, 1'b0);
        for (int p = 0; p < 8; p++) begin
            for (int k = 0; k < 8 - p; k++) pulse(B_U, 1'b0);
            pulse(B_L, 1'b0);
        end
        settle();
        check("build_Ai", Ai, 32'h1234_5678);
        pulse(B_L, 1'b0);
        repeat (8) cyc(1'b1, B_U | B_C, 1'b0);
        cyc(1'b1, 5'b0, 1'b0);
        settle();
        check("uc_Ai_0", Ai, 32'h0);
        check("uc_cursor_0", 32'(cursor), 32'd0);

`ifdef HEX_OPERAND_EDITOR_BCD_EN
        repeat (9) pulse(B_U, 1'b0);
        pulse(B_U, 1'b0);
        settle();
        check("bcd_up_wrap", Ai, 32'h0);
        pulse(B_D, 1'b0);
        settle();
        check("bcd_dn_wrap", Ai, 32'h9);
`endif

        // Randomized phase: buttons held for random lengths, occasional reset.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] b;
            logic       s;
            logic       r;
            int         len;
            b   = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 2) != 0) b = 5'(1 << $urandom_range(0, 4));
            if ($urandom_range(0, 3) == 0) b = 5'b0;
            s   = 1'($urandom_range(0, 1));
            r   = ($urandom_range(0, 60) != 0);
            len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) s = ~s;
                cyc(r, b, s);
            end
        end
        cyc(1'b1, 5'b0, 1'b0);

        repeat (4) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
